// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives a synchronous-read instruction memory and
// registers the IF/ID pipeline register, squashing wrong-path fetches on redirect.
module fetch_stage #(
   parameter int                   PC_W     = 10,
   parameter int                   INSTR_W  = 32,
   parameter logic [PC_W-1:0]      RESET_PC = '0,
   parameter logic [INSTR_W-1:0]   NOP      = '0,
   parameter int                   CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               PCSrc,
   input  logic [PC_W-1:0]    adderResult,
   input  logic               jump,
   input  logic [PC_W-1:0]    jaddress,
   input  logic               jr,
   input  logic [PC_W-1:0]    jrTarget,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instruction,
   output logic [PC_W-1:0]    PCPlus1,
   output logic               instrValid,
   output logic [CNT_W-1:0]   flushCount
);

   typedef enum logic {PRIME, RUN} state_e;

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    pcp1_q, pcp1_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   flush_q, flush_d;

   logic               redirect;
   logic [PC_W-1:0]    pc_plus1;
   logic [PC_W-1:0]    target;

   assign redirect = ~stall & (jr | jump | PCSrc);
   assign pc_plus1 = pc_q + PC_W'(1);
   assign target   = jr ? jrTarget : (jump ? jaddress : adderResult);

   // NOTE: every variable gets its hold value first so no path leaves it
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pcp1_d  = pcp1_q;
      valid_d = valid_q;
      flush_d = flush_q;
      unique case (state_q)
         PRIME: begin
            state_d = RUN;
            pc_d    = RESET_PC;
            instr_d = NOP;
            valid_d = 1'b0;
         end
         RUN: begin
            if (stall) begin
               // Stall outranks any redirect; decode re-presents it later.
            end else if (redirect) begin
               pc_d    = target;
               instr_d = NOP;
               valid_d = 1'b0;
               pcp1_d  = pc_plus1;
               flush_d = (&flush_q) ? flush_q : flush_q + CNT_W'(1);
            end else begin
               pc_d    = pc_plus1;
               instr_d = imem_rdata;
               valid_d = 1'b1;
               pcp1_d  = pc_plus1;
            end
         end
         default: state_d = PRIME;
      endcase
   end

   // Next-PC goes straight to memory so read data lines up with pc_q next cycle.
   assign imem_addr = pc_d;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= PRIME;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         pcp1_q  <= '0;
         valid_q <= 1'b0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pcp1_q  <= pcp1_d;
         valid_q <= valid_d;
         flush_q <= flush_d;
      end
   end

   assign instruction = instr_q;
   assign PCPlus1     = pcp1_q;
   assign instrValid  = valid_q;
   assign flushCount  = flush_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural fetch model checked every cycle, plus
// hand-computed checkpoints from directed redirect/stall/wrap/reset scenarios.
module tb_fetch_stage;

   localparam int          PC_W    = 10;
   localparam int          INSTR_W = 32;
   localparam int          CNT_W   = 16;
   localparam logic [9:0]  RST_PC  = 10'h000;
   localparam logic [31:0] NOP_W   = 32'h0000_0000;

   logic               clk = 1'b0;
   logic               rst;
   logic               stall, PCSrc, jump, jr;
   logic [PC_W-1:0]    adderResult, jaddress, jrTarget;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] instruction;
   logic [PC_W-1:0]    PCPlus1;
   logic               instrValid;
   logic [CNT_W-1:0]   flushCount;

   always #5 clk = ~clk;

   fetch_stage #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RST_PC), .NOP(NOP_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .PCSrc(PCSrc), .adderResult(adderResult),
      .jump(jump), .jaddress(jaddress), .jr(jr), .jrTarget(jrTarget),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instruction(instruction),
      .PCPlus1(PCPlus1), .instrValid(instrValid), .flushCount(flushCount)
   );

   // Synchronous-read instruction memory, mem[i] = 0x1000_0000 + i.
   logic [31:0] mem [0:1023];
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
      imem_rdata = '0;
   end
   always @(posedge clk) imem_rdata <= mem[imem_addr];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The model tracks the architectural fetch address and what ID should hold;
   // instruction words come from the arithmetic memory pattern, not the array.
   bit          m_run;
   logic [9:0]  m_pc;
   logic [31:0] m_instr;
   logic [9:0]  m_pcp1;
   bit          m_valid;
   int          m_flush;

   function automatic logic [31:0] word_at(input logic [9:0] a);
      return 32'h1000_0000 + 32'(a);
   endfunction

   function automatic bit any_redirect();
      return !stall && (jr || jump || PCSrc);
   endfunction

   function automatic logic [9:0] redirect_target();
      if (jr)   return jrTarget;
      if (jump) return jaddress;
      return adderResult;
   endfunction

   function automatic logic [9:0] expected_fetch_addr();
      if (!rst || !m_run)  return RST_PC;
      if (stall)           return m_pc;
      if (any_redirect())  return redirect_target();
      return m_pc + 10'd1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_run   <= 1'b0;
         m_pc    <= RST_PC;
         m_instr <= NOP_W;
         m_pcp1  <= '0;
         m_valid <= 1'b0;
         m_flush <= 0;
      end else if (!m_run) begin
         m_run   <= 1'b1;
         m_instr <= NOP_W;
         m_valid <= 1'b0;
      end else if (stall) begin
         m_pc <= m_pc;
      end else if (any_redirect()) begin
         m_instr <= NOP_W;
         m_valid <= 1'b0;
         m_pcp1  <= m_pc + 10'd1;
         m_pc    <= redirect_target();
         m_flush <= (m_flush < 65535) ? m_flush + 1 : 65535;
      end else begin
         m_instr <= word_at(m_pc);
         m_valid <= 1'b1;
         m_pcp1  <= m_pc + 10'd1;
         m_pc    <= m_pc + 10'd1;
      end
   end

   bit chk_en = 1'b0;

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("cyc_instruction", instruction, m_instr);
         check("cyc_pcplus1", 32'(PCPlus1), 32'(m_pcp1));
         check("cyc_valid", 32'(instrValid), 32'(m_valid));
         check("cyc_flushcount", 32'(flushCount), 32'(m_flush));
         check("cyc_imem_addr", 32'(imem_addr), 32'(expected_fetch_addr()));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      stall = 1'b0; PCSrc = 1'b0; jump = 1'b0; jr = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      adderResult = '0; jaddress = '0; jrTarget = '0;
      cyc(); cyc();
      chk_en = 1'b1;
      check("reset_valid", 32'(instrValid), 32'd0);
      check("reset_instr", instruction, 32'h0);
      check("reset_flush", 32'(flushCount), 32'd0);
      check("reset_imem_addr", 32'(imem_addr), 32'(RST_PC));

      // Reset release: PRIME bubble, then sequential words.
      rst = 1'b1;
      cyc();
      check("prime_valid", 32'(instrValid), 32'd0);
      check("prime_instr", instruction, 32'h0);
      cyc();
      check("first_instr", instruction, 32'h1000_0000);
      check("first_pcp1", 32'(PCPlus1), 32'd1);
      check("first_valid", 32'(instrValid), 32'd1);
      cyc();
      check("second_instr", instruction, 32'h1000_0001);
      check("second_pcp1", 32'(PCPlus1), 32'd2);
      cyc(); cyc(); cyc();
      check("pre_branch_pcp1", 32'(PCPlus1), 32'd5);

      // Taken branch while PC=5.
      PCSrc = 1'b1; adderResult = 10'h040;
      cyc();
      idle_inputs();
      check("branch_bubble_valid", 32'(instrValid), 32'd0);
      check("branch_bubble_instr", instruction, NOP_W);
      check("branch_flush", 32'(flushCount), 32'd1);
      cyc();
      check("branch_target_instr", instruction, 32'h1000_0040);
      check("branch_target_pcp1", 32'(PCPlus1), 32'h041);

      // All three redirect strobes together: jr wins, counted once.
      jr = 1'b1; jump = 1'b1; PCSrc = 1'b1;
      jrTarget = 10'h100; jaddress = 10'h200; adderResult = 10'h300;
      cyc();
      idle_inputs();
      check("multi_flush", 32'(flushCount), 32'd2);
      check("multi_bubble_valid", 32'(instrValid), 32'd0);
      cyc();
      check("multi_target_instr", instruction, 32'h1000_0100);
      check("multi_target_pcp1", 32'(PCPlus1), 32'h101);

      // Stall for 3 cycles with a branch held; stall wins.
      stall = 1'b1; PCSrc = 1'b1; adderResult = 10'h3FF;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("stall_instr", instruction, 32'h1000_0100);
         check("stall_pcp1", 32'(PCPlus1), 32'h101);
         check("stall_flush", 32'(flushCount), 32'd2);
         check("stall_imem_addr", 32'(imem_addr), 32'h101);
      end
      stall = 1'b0;
      cyc();
      idle_inputs();
      check("unstall_flush", 32'(flushCount), 32'd3);
      check("unstall_valid", 32'(instrValid), 32'd0);

      // PC=0x3FF wraps to 0.
      cyc();
      check("wrap_instr", instruction, 32'h1000_03FF);
      check("wrap_pcp1", 32'(PCPlus1), 32'h000);
      cyc();
      check("wrap_next_instr", instruction, 32'h1000_0000);
      check("wrap_next_pcp1", 32'(PCPlus1), 32'd1);
      cyc();

      // Asynchronous reset between edges.
      #1 rst = 1'b0;
      #1;
      check("midrst_valid", 32'(instrValid), 32'd0);
      check("midrst_instr", instruction, 32'h0);
      check("midrst_pcp1", 32'(PCPlus1), 32'd0);
      check("midrst_flush", 32'(flushCount), 32'd0);
      check("midrst_imem_addr", 32'(imem_addr), 32'(RST_PC));
      cyc();
      rst = 1'b1;
      cyc();
      check("midrst_prime_valid", 32'(instrValid), 32'd0);
      cyc();
      check("midrst_first_instr", instruction, 32'h1000_0000);
      check("midrst_first_valid", 32'(instrValid), 32'd1);

      // Saturation of the flush counter.
      PCSrc = 1'b1; adderResult = 10'h010;
      repeat (70000) @(posedge clk);
      #2;
      check("sat_flush", 32'(flushCount), 32'h0000_FFFF);
      cyc();
      idle_inputs();
      check("sat_hold_flush", 32'(flushCount), 32'h0000_FFFF);
      cyc(); cyc();

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
